// File: rtl/control_fsm_pkg.sv
// Shared types for the multicycle control FSM: state enum, opcodes, mux/ALU encodings
// and the packed control word produced by the output decoder.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       xor_zero;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction fields in, datapath control strobes/selects out. mem_ready only exists
// when MEM_WAIT_EN is defined.
interface control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite;
  logic       Branch;
  logic       XorZero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ResultSrc;
  logic       illegal_instr;

`ifdef MEM_WAIT_EN
  modport master (output opcode, funct3, mem_ready,
                  input PCWrite, Branch, XorZero, IorD, MemWrite, IRWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_instr);
  modport slave  (input opcode, funct3, mem_ready,
                  output PCWrite, Branch, XorZero, IorD, MemWrite, IRWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_instr);
`else
  modport master (output opcode, funct3,
                  input PCWrite, Branch, XorZero, IorD, MemWrite, IRWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_instr);
  modport slave  (input opcode, funct3,
                  output PCWrite, Branch, XorZero, IorD, MemWrite, IRWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_instr);
`endif
endinterface

// File: rtl/control_fsm_out_decode.sv
// Combinational state -> control word decode. Only DECODE/BRANCH look at the
// instruction fields; mem_rdy gates the memory-side strobes.
module control_out_decode
  import control_fsm_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_rdy;
        ctrl.pc_write   = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !op_supported(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.iord       = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = mem_rdy;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        case (funct3)
          F3_BEQ:  ctrl.branch = 1'b1;
          F3_BNE: begin
            ctrl.branch   = 1'b1;
            ctrl.xor_zero = 1'b1;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle Moore control FSM: state register + next-state logic; outputs come from
// control_out_decode. Define MEM_WAIT_EN to add mem_ready wait states to memory states.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.slave  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   mem_rdy;

`ifdef MEM_WAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  control_out_decode u_dec (
    .state   (state_q),
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Strobes are suppressed for as long as rst is held, so the state sitting in the
  // register during reset can never write anything.
  always_comb begin
    ctrl_o = ctrl;
    if (rst) begin
      ctrl_o.pc_write  = 1'b0;
      ctrl_o.branch    = 1'b0;
      ctrl_o.mem_write = 1'b0;
      ctrl_o.ir_write  = 1'b0;
      ctrl_o.reg_write = 1'b0;
      ctrl_o.illegal   = 1'b0;
    end
  end

  assign bus.PCWrite       = ctrl_o.pc_write;
  assign bus.Branch        = ctrl_o.branch;
  assign bus.XorZero       = ctrl_o.xor_zero;
  assign bus.IorD          = ctrl_o.iord;
  assign bus.MemWrite      = ctrl_o.mem_write;
  assign bus.IRWrite       = ctrl_o.ir_write;
  assign bus.RegWrite      = ctrl_o.reg_write;
  assign bus.ALUSrcA       = ctrl_o.alu_src_a;
  assign bus.ALUSrcB       = ctrl_o.alu_src_b;
  assign bus.ALUOp         = ctrl_o.alu_op;
  assign bus.ResultSrc     = ctrl_o.result_src;
  assign bus.illegal_instr = ctrl_o.illegal;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 opcode  input  7  instruction opcode field from IR.
REQ-004 funct3  input  3  instruction funct3 field from IR.
REQ-005 PCWrite  output  1  unconditional PC update strobe to PC enable logic.
REQ-006 Branch  output  1  conditional branch strobe to PC enable logic.
REQ-007 XorZero  output  1  branch sense; 0 = take on Zero, 1 = take on not-Zero.
REQ-008 IorD  output  1  memory address select; 0 = PC, 1 = ALUOut.
REQ-009 MemWrite / IRWrite / RegWrite  output  1 each  write strobes.
REQ-010 ALUSrcA  output  2  00 PC, 01 OldPC, 10 register A.
REQ-011 ALUSrcB  output  2  00 register B, 01 ImmExt, 10 constant 4.
REQ-012 ALUOp  output  2  00 add, 01 sub, 10 decode by funct fields.
REQ-013 ResultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-014 illegal_instr  output  1  one-cycle pulse on unsupported opcode/funct3.
REQ-015 mem_ready  input  1  memory access complete (present only with MEM_WAIT_EN).

Function
REQ-016 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL; outputs registered-state-decoded, no opcode-dependent outputs except in DECODE/BRANCH.
REQ-017 Outputs not listed for a state SHALL be 0 (selects 00).
REQ-018 FETCH: IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1; next DECODE.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, else FETCH with illegal_instr=1.
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if opcode 0000011, else MEMWRITE.
REQ-021 MEMREAD: ResultSrc=00, IorD=1; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-022 MEMWRITE: ResultSrc=00, IorD=1, MemWrite=1; next FETCH.
REQ-023 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both next ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; XorZero=0 for funct3 000, 1 for 001; other funct3 -> Branch=0, illegal_instr=1; next FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, RegWrite=1; next FETCH.
REQ-027 Latency: R/I-type 4 cycles, load 5, store 4, branch 3, JAL 3 (without wait states).
REQ-028 Unreachable state encodings SHALL return to FETCH next cycle with all strobes 0.

Reset
REQ-029 rst=1 at a clock edge forces state FETCH regardless of current state, including mid-instruction; no strobe from the aborted state SHALL appear after that edge.
REQ-030 While rst=1 all write strobes (PCWrite, Branch, MemWrite, IRWrite, RegWrite) and illegal_instr SHALL be 0; first FETCH strobes occur in the first cycle after rst deasserts.

Configuration
REQ-031 Macro MEM_WAIT_EN: when defined, port mem_ready exists; FETCH, MEMREAD, MEMWRITE hold state while mem_ready=0, asserting PCWrite/IRWrite/MemWrite only in the cycle mem_ready=1.
REQ-032 Without MEM_WAIT_EN: no mem_ready port; memory states always last exactly one cycle.

Structure
REQ-033 Shared package SHALL hold the state enum, opcode constants, and ALUSrcA/ALUSrcB/ALUOp/ResultSrc encodings.
REQ-034 One sub-module, control_out_decode (state -> output vector, combinational); next-state logic and state register stay in control_fsm.

Verification
REQ-035 rst 1 for 2 cycles, then opcode 0110011 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; back to FETCH cycle 5.
REQ-036 opcode 0000011 -> 5-cycle sequence ending MEMWB with ResultSrc=01, RegWrite=1; opcode 0100011 -> MemWrite=1 in cycle 4 only.
REQ-037 opcode 1100011, funct3 001 -> BRANCH cycle shows Branch=1, XorZero=1; funct3 000 -> XorZero=0; funct3 100 -> Branch=0, illegal_instr=1.
REQ-038 opcode 1111111 -> illegal_instr=1 in DECODE, FETCH next cycle; rst asserted during MEMREAD -> FETCH next cycle, no RegWrite.
REQ-039 MEM_WAIT_EN defined, mem_ready=0 for 3 cycles in FETCH -> state holds, IRWrite=0, PCWrite=0; mem_ready=1 -> IRWrite=1, PCWrite=1 that cycle, DECODE next.
